// File: rtl/complex_accum.sv
// Block accumulator for complex products: sums 2**LOGN valid samples at full precision,
// then rounds, shifts and saturates the block sum into one output pulse per block.
module complex_accum #(
    parameter int IW    = 33,
    parameter int LOGN  = 4,
    parameter int SHIFT = 4,
    parameter int OW    = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic signed [IW-1:0] in_re,
    input  logic signed [IW-1:0] in_im,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_re,
    output logic signed [OW-1:0] out_im,
    output logic                 out_sat
);
    localparam int ACCW = IW + LOGN;
    localparam logic [LOGN-1:0] LAST_CNT = '1;
    // Half an output LSB; collapses to zero when SHIFT is 0.
    localparam logic signed [ACCW:0] RND = ((ACCW + 1)'(1) << SHIFT) >> 1;
    localparam logic signed [ACCW:0] SAT_MAX = {{(ACCW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [ACCW:0] SAT_MIN = {{(ACCW + 2 - OW){1'b1}}, {(OW - 1){1'b0}}};

    // Component index 0 is real, 1 is imaginary.
    logic [1:0][ACCW-1:0] samp_ext;
    logic [1:0][ACCW-1:0] acc_reg;
    logic [1:0][ACCW-1:0] dump_reg;
    logic [1:0][OW-1:0]   sat_val;
    logic [1:0]           sat_hit;
    logic [1:0][OW-1:0]   out_reg;
    logic [LOGN-1:0]      cnt_reg;
    logic                 dump_pend_reg;
    logic                 out_valid_reg;
    logic                 out_sat_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_comp
            logic signed [IW-1:0]   samp;
            logic signed [ACCW:0]   rnd_sum;
            logic signed [ACCW:0]   shifted;

            assign samp          = (gi == 0) ? in_re : in_im;
            assign samp_ext[gi]  = {{LOGN{samp[IW-1]}}, samp};
            // One extra bit of headroom so the rounding offset cannot wrap the sum.
            assign rnd_sum       = {dump_reg[gi][ACCW-1], dump_reg[gi]} + RND;
            assign shifted       = rnd_sum >>> SHIFT;
            assign sat_hit[gi]   = (shifted > SAT_MAX) || (shifted < SAT_MIN);
            assign sat_val[gi]   = (shifted > SAT_MAX) ? {1'b0, {(OW - 1){1'b1}}} :
                                   (shifted < SAT_MIN) ? {1'b1, {(OW - 1){1'b0}}} :
                                   shifted[OW-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            acc_reg       <= '0;
            dump_reg      <= '0;
            dump_pend_reg <= 1'b0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_sat_reg   <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            out_sat_reg   <= 1'b0;
            dump_pend_reg <= 1'b0;
            // A flush on the rescale cycle cancels the pending block result.
            if (dump_pend_reg && !clr) begin
                out_reg       <= sat_val;
                out_valid_reg <= 1'b1;
                out_sat_reg   <= |sat_hit;
            end
            if (clr) begin
                cnt_reg <= '0;
            end else if (in_valid) begin
                cnt_reg <= cnt_reg + 1'b1;
                if (cnt_reg == '0) begin
                    acc_reg <= samp_ext;
                end else if (cnt_reg == LAST_CNT) begin
                    for (int i = 0; i < 2; i++) begin
                        dump_reg[i] <= acc_reg[i] + samp_ext[i];
                    end
                    dump_pend_reg <= 1'b1;
                end else begin
                    for (int i = 0; i < 2; i++) begin
                        acc_reg[i] <= acc_reg[i] + samp_ext[i];
                    end
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_sat   = out_sat_reg;
    assign out_re    = out_reg[0];
    assign out_im    = out_reg[1];

endmodule
